// File: rtl/poly_horner_pipe_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | poly_pkg : shared types and arithmetic helpers for poly_horner_pipe      |
// | Rev 1.0  : initial release                                               |
// +--------------------------------------------------------------------------+
package poly_pkg;

    // Widest operand the helpers work on; WIDTHOUT+WIDTHIN must not exceed it.
    localparam int c_WIDE_W = 64;

    typedef logic signed [c_WIDE_W-1:0] wide_t;

    // Coefficient bank element before it is narrowed to WIDTHOUT.
    typedef logic [c_WIDE_W-1:0] coef_word_t;

    // ck = trunc(2^fracout / k!); once k! exceeds the numerator the quotient is 0.
    function automatic coef_word_t coef_default(input int k, input int fracout);
        coef_word_t num;
        coef_word_t fact;
        num  = coef_word_t'(1) << fracout;
        fact = coef_word_t'(1);
        for (int i = 2; i <= k; i++) begin
            if (fact <= num) begin
                fact = fact * coef_word_t'(i);
            end
        end
        return num / fact;
    endfunction

    // Full signed product, then arithmetic shift (floor); caller keeps the low bits.
    function automatic wide_t horner_mul(input wide_t acc, input wide_t x, input int fracin);
        wide_t p;
        p = acc * x;
        return p >>> fracin;
    endfunction

endpackage
`default_nettype wire

// File: rtl/poly_horner_pipe_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | poly_horner_pipe_if : sample stream, result stream and coefficient port  |
// | Rev 1.0  : initial release                                               |
// +--------------------------------------------------------------------------+
interface poly_horner_pipe_if #(
    parameter int ORDER    = 5,
    parameter int WIDTHIN  = 16,
    parameter int WIDTHOUT = 32
);
    localparam int c_ADDR_W = $clog2(ORDER + 1);

    logic                i_valid;
    logic                o_ready;
    logic [WIDTHIN-1:0]  i_x;
    logic                o_valid;
    logic                i_ready;
    logic [WIDTHOUT-1:0] o_y;
    logic                cfg_we;
    logic [c_ADDR_W-1:0] cfg_addr;
    logic [WIDTHOUT-1:0] cfg_wdata;
    logic                cfg_ready;

    modport master (
        output i_valid, i_x, i_ready, cfg_we, cfg_addr, cfg_wdata,
        input  o_ready, o_valid, o_y, cfg_ready
    );

    modport slave (
        input  i_valid, i_x, i_ready, cfg_we, cfg_addr, cfg_wdata,
        output o_ready, o_valid, o_y, cfg_ready
    );
endinterface
`default_nettype wire

// File: rtl/poly_horner_pipe_stage.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | poly_horner_stage : one Horner step acc*x>>FRACIN + ck with its register |
// | Rev 1.0  : initial release                                               |
// +--------------------------------------------------------------------------+
module poly_horner_stage
    import poly_pkg::*;
#(
    parameter int WIDTHIN  = 16,
    parameter int FRACIN   = 14,
    parameter int WIDTHOUT = 32
) (
    input  wire logic                clk,
    input  wire logic                reset_n,
    input  wire logic                en_i,
    input  wire logic                valid_i,
    input  wire logic [WIDTHOUT-1:0] acc_i,
    input  wire logic [WIDTHIN-1:0]  x_i,
    input  wire logic [WIDTHOUT-1:0] coef_i,
    output logic                     valid_o,
    output logic [WIDTHOUT-1:0]      acc_o,
    output logic [WIDTHIN-1:0]       x_o
);

    logic signed [WIDTHOUT-1:0] acc_sg;
    logic signed [WIDTHIN-1:0]  x_sg;
    wide_t                      prod;
    logic [WIDTHOUT-1:0]        acc_d;

    logic                       valid_q;
    logic [WIDTHOUT-1:0]        acc_q;
    logic [WIDTHIN-1:0]         x_q;

    assign acc_sg = acc_i;
    assign x_sg   = x_i;
    assign prod   = horner_mul(wide_t'(acc_sg), wide_t'(x_sg), FRACIN);
    // Low WIDTHOUT bits only: overflow wraps rather than saturating.
    assign acc_d  = prod[WIDTHOUT-1:0] + coef_i;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            valid_q <= 1'b0;
            acc_q   <= '0;
            x_q     <= '0;
        end else if (en_i) begin
            valid_q <= valid_i;
            acc_q   <= acc_d;
            x_q     <= x_i;
        end
    end

    assign valid_o = valid_q;
    assign acc_o   = acc_q;
    assign x_o     = x_q;

endmodule
`default_nettype wire

// File: rtl/poly_horner_pipe.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | poly_horner_pipe : ORDER-stage Horner polynomial evaluator, global stall |
// | Rev 1.0  : initial release                                               |
// +--------------------------------------------------------------------------+
module poly_horner_pipe
    import poly_pkg::*;
#(
    parameter int ORDER    = 5,
    parameter int WIDTHIN  = 16,
    parameter int FRACIN   = 14,
    parameter int WIDTHOUT = 32,
    parameter int FRACOUT  = 25
) (
    input  wire logic          clk,
    input  wire logic          reset_n,
    poly_horner_pipe_if.slave  bus
);

    localparam int c_ADDR_W = $clog2(ORDER + 1);

    logic                advance;
    logic                cfg_wr;
    logic                accept;
    logic [ORDER:0]      valid_w;
    logic [WIDTHOUT-1:0] acc_w  [ORDER+1];
    logic [WIDTHIN-1:0]  x_w    [ORDER+1];
    logic [WIDTHOUT-1:0] coef_w [ORDER+1];
    logic [WIDTHIN-1:0]  x_tail_unused;

    // Writes are only taken on an empty pipe, so no sample ever sees a mixed bank.
    assign bus.cfg_ready = ~|valid_w[ORDER:1];
    assign cfg_wr        = bus.cfg_we & bus.cfg_ready;
    assign advance       = ~valid_w[ORDER] | bus.i_ready;
    assign bus.o_ready   = advance & ~cfg_wr;
    assign accept        = bus.i_valid & bus.o_ready;

    generate
        for (genvar k = 0; k <= ORDER; k++) begin : g_coef
            localparam logic [WIDTHOUT-1:0] c_DFLT = WIDTHOUT'(coef_default(k, FRACOUT));
            logic [WIDTHOUT-1:0] coef_q;

            always_ff @(posedge clk or negedge reset_n) begin
                if (!reset_n) begin
                    coef_q <= c_DFLT;
                end else if (cfg_wr && (bus.cfg_addr == c_ADDR_W'(k))) begin
                    coef_q <= bus.cfg_wdata;
                end
            end

            assign coef_w[k] = coef_q;
        end
    endgenerate

    // Slot 0 is the stage-1 operand: the top coefficient stands in for acc.
    assign valid_w[0] = accept;
    assign acc_w[0]   = coef_w[ORDER];
    assign x_w[0]     = bus.i_x;

    generate
        for (genvar s = 1; s <= ORDER; s++) begin : g_stage
            poly_horner_stage #(
                .WIDTHIN  (WIDTHIN),
                .FRACIN   (FRACIN),
                .WIDTHOUT (WIDTHOUT)
            ) u_stage (
                .clk     (clk),
                .reset_n (reset_n),
                .en_i    (advance),
                .valid_i (valid_w[s-1]),
                .acc_i   (acc_w[s-1]),
                .x_i     (x_w[s-1]),
                .coef_i  (coef_w[ORDER-s]),
                .valid_o (valid_w[s]),
                .acc_o   (acc_w[s]),
                .x_o     (x_w[s])
            );
        end
    endgenerate

    assign x_tail_unused = x_w[ORDER];
    assign bus.o_valid   = valid_w[ORDER];
    assign bus.o_y       = acc_w[ORDER];

endmodule
`default_nettype wire

// File: doc/poly_horner_pipe.md
# poly_horner_pipe

Parametrised, fully pipelined Horner-form polynomial evaluator: y = c0 + c1·x + … + cN·x^N with N = ORDER, one Horner step per pipeline stage, one result per cycle. It generalises the fixed 5-term e^x pipeline. Additions over it:
- Order and fixed-point formats are parameters.
- Coefficients are runtime-programmable.
- Real valid/ready backpressure: outputs are held, not dropped.

It sits between the sample source and the downstream consumer in the datapath.

## Interface
- ORDER, 5: polynomial order N (≥1); also the pipeline depth.
- WIDTHIN, 16: signed input width.
- FRACIN, 14: fractional bits of x (Q2.14 by default).
- WIDTHOUT, 32: signed accumulator, coefficient and output width.
- FRACOUT, 25: fractional bits of coefficients and y (Q7.25 by default).
- clk  in  1  clock, all state on rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- i_valid  in  1  input sample valid.
- o_ready  out  1  block accepts a sample this cycle.
- i_x  in  WIDTHIN  signed sample x.
- o_valid  out  1  o_y holds a result.
- i_ready  in  1  downstream accepts the result.
- o_y  out  WIDTHOUT  signed result y.
- cfg_we  in  1  coefficient write strobe.
- cfg_addr  in  $clog2(ORDER+1)  coefficient index k (ck).
- cfg_wdata  in  WIDTHOUT  coefficient value, Q(WIDTHOUT-FRACOUT).FRACOUT.
- cfg_ready  out  1  pipeline empty; a write is accepted this cycle.

## Operation
- Coefficient bank: ORDER+1 registers.
  - Reset values are the e^x Taylor terms from the package: c0=c1=0x0200_0000, c2=0x0100_0000, c3=0x0055_5555, c4=0x0015_5555, c5=0x0004_4444 at defaults.
  - For other ORDER, ck=trunc(2^FRACOUT/k!).
- Horner step (function h):
  - Product p = acc·x, full WIDTHOUT+WIDTHIN signed.
  - Arithmetic shift right by FRACIN (truncation toward −∞).
  - Keep the low WIDTHOUT bits (wrap, no saturation).
  - Add ck, modulo 2^WIDTHOUT.
- Stage s (1..ORDER) registers acc_s, x_s and valid_s.
  - acc_1 = h(c_ORDER, i_x) + c_(ORDER−1).
  - acc_s = h(acc_(s−1), x_(s−1)) + c_(ORDER−s).
  - o_y = acc_ORDER; o_valid = valid_ORDER.
- Flow control is a global stall.
  - advance = ~valid_ORDER | i_ready.
  - All stages shift only on advance. Bubbles are not collapsed.
- o_ready = advance & ~(cfg_we & cfg_ready).
- Accept = i_valid & o_ready. On advance without accept, valid_1 loads 0.
- cfg_ready = ~|valid_1..ORDER.
- Write = cfg_we & cfg_ready.
  - It updates c[cfg_addr] at the edge.
  - cfg_addr > ORDER is ignored.
  - A write blocks input acceptance in that cycle.
  - cfg_we while cfg_ready=0 is dropped, with no side effect.
- Reset (any time, including mid-stream):
  - Clears all valid bits, acc/x registers and o_y to 0.
  - Restores default coefficients. In-flight samples are discarded.

## Timing
- Reset values:
  - o_valid=0, o_y=0, cfg_ready=1.
  - o_ready=1 unless cfg_we is high.
- Latency: a sample accepted at edge E appears with o_valid=1 after edge E+ORDER−1, provided there is no stall.
- Throughput: 1 sample/cycle while i_ready=1.
- While o_valid=1 and i_ready=0:
  - o_y, o_valid and all stages hold.
  - o_ready=0.
- i_ready may rise in the same cycle as o_valid: the result transfers and a new sample is accepted together.
- A new coefficient applies to samples accepted after the write edge only. Mixing within one sample is impossible because writes need an empty pipe.

## Structure
- Package poly_pkg holds:
  - the default-coefficient function (ck = 2^FRACOUT/k!, truncated);
  - the coefficient array typedef;
  - the signed-multiply-shift-truncate function h.
- Sub-module poly_horner_stage holds one Horner step plus its acc/x/valid register and enable. It is instantiated ORDER times via generate; stage 1 is fed the constant operand c_ORDER.
- Top level holds the coefficient bank, config handshake, advance logic and output mapping.

## Test plan
- Reset → o_valid=0, o_y=0, o_ready=1, cfg_ready=1. Assert reset_n low mid-stream → o_valid drops asynchronously and no stale result appears after release.
- Defaults, i_ready=1, send x=0x0000, then 0x4000 (1.0), then 0xC000 (−1.0) back-to-back:
  - Expect 0x0200_0000, 0x056E_EEEE, 0x00BB_BBBC.
  - Outputs arrive on three consecutive cycles, ORDER−1 edges after each accept.
- Backpressure: 10 samples, i_ready toggled pseudo-randomly → no result lost or duplicated, order preserved, o_y stable while stalled.
- Reprogram on an empty pipe:
  - Write c0..c5 = 0 except c1=0x0200_0000, then send x=0x2000 (0.5) → y=0x0100_0000.
  - Write cfg_addr=7 → no coefficient changes.
- Write while busy: assert cfg_we while a sample is in flight → cfg_ready=0, write dropped, result uses the old coefficients.
- Write on an empty pipe with i_valid=1 in the same cycle → o_ready=0 that cycle, the sample is accepted next cycle and uses the new coefficient.
